// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: PS/2 keyboard receiver that turns arrow-key
// make/break sequences into a 2-bit snake direction (0 L, 1 R, 2 U, 3 D).
// Optional build macro PS2_DIR_WASD_EN: also accept the base WASD keys.
module ps2_direction_decoder #(
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [1:0] dir,
   output logic       dir_strobe,
   output logic       key_held,
   output logic       frame_err
);

   localparam logic [15:0] TO16 = TIMEOUT[15:0];

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_e;
   typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_e;

   // {valid, code} for the E0-prefixed arrow keys
   function automatic logic [2:0] arrow_code(input logic [7:0] b);
      case (b)
         8'h6B:   arrow_code = 3'b100;
         8'h74:   arrow_code = 3'b101;
         8'h75:   arrow_code = 3'b110;
         8'h72:   arrow_code = 3'b111;
         default: arrow_code = 3'b000;
      endcase
   endfunction

`ifdef PS2_DIR_WASD_EN
   // {valid, code} for the unprefixed WASD keys
   function automatic logic [2:0] wasd_code(input logic [7:0] b);
      case (b)
         8'h1C:   wasd_code = 3'b100;
         8'h23:   wasd_code = 3'b101;
         8'h1D:   wasd_code = 3'b110;
         8'h1B:   wasd_code = 3'b111;
         default: wasd_code = 3'b000;
      endcase
   endfunction
`endif

   logic       clk_s1_q, clk_s2_q, clk_s3_q;
   logic       dat_s1_q, dat_s2_q;
   logic       fall;

   rx_e        rx_q;
   logic [2:0] cnt_q;
   logic [7:0] sr_q;
   logic       par_q;
   logic [15:0] wd_q;
   logic       byte_valid_q;
   logic [7:0] byte_q;
   logic       frame_err_q;

   dec_e       dec_q;
   logic [1:0] dir_q;
   logic       dir_strobe_q;
   logic       key_held_q;
   logic [7:0] held_code_q;
   logic       held_ext_q;

   logic [2:0] arrow_hit;
   assign arrow_hit = arrow_code(byte_q);
`ifdef PS2_DIR_WASD_EN
   logic [2:0] wasd_hit;
   assign wasd_hit = wasd_code(byte_q);
`endif

   // Two-flop synchronisers; idle-high preset so reset never fakes an edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2_dat;
         dat_s2_q <= dat_s1_q;
      end
   end

   assign fall = clk_s3_q & ~clk_s2_q;

   // Frame receiver with mid-frame watchdog; a real edge beats expiry
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_q         <= RX_IDLE;
         cnt_q        <= '0;
         sr_q         <= '0;
         par_q        <= 1'b0;
         wd_q         <= '0;
         byte_valid_q <= 1'b0;
         byte_q       <= '0;
         frame_err_q  <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         if (rx_q == RX_IDLE || fall) begin
            wd_q <= '0;
         end else if (wd_q == TO16) begin
            wd_q        <= '0;
            rx_q        <= RX_IDLE;
            cnt_q       <= '0;
            frame_err_q <= 1'b1;
         end else begin
            wd_q <= wd_q + 16'd1;
         end
         if (fall) begin
            case (rx_q)
               RX_IDLE: begin
                  if (!dat_s2_q) begin
                     rx_q  <= RX_DATA;
                     cnt_q <= '0;
                  end
               end
               RX_DATA: begin
                  sr_q  <= {dat_s2_q, sr_q[7:1]};
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) rx_q <= RX_PARITY;
               end
               RX_PARITY: begin
                  par_q <= dat_s2_q;
                  rx_q  <= RX_STOP;
               end
               default: begin
                  if (dat_s2_q && (^{par_q, sr_q})) begin
                     byte_valid_q <= 1'b1;
                     byte_q       <= sr_q;
                  end else begin
                     frame_err_q  <= 1'b1;
                  end
                  rx_q <= RX_IDLE;
               end
            endcase
         end
      end
   end

   // Prefix tracker and direction outputs; moves only on good bytes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dec_q        <= D_IDLE;
         dir_q        <= 2'd1;
         dir_strobe_q <= 1'b0;
         key_held_q   <= 1'b0;
         held_code_q  <= '0;
         held_ext_q   <= 1'b0;
      end else begin
         dir_strobe_q <= 1'b0;
         if (byte_valid_q) begin
            case (dec_q)
               D_IDLE: begin
                  if (byte_q == 8'hE0) dec_q <= D_EXT;
                  else if (byte_q == 8'hF0) dec_q <= D_BRK;
`ifdef PS2_DIR_WASD_EN
                  else if (wasd_hit[2]) begin
                     dir_q        <= wasd_hit[1:0];
                     dir_strobe_q <= 1'b1;
                     key_held_q   <= 1'b1;
                     held_code_q  <= byte_q;
                     held_ext_q   <= 1'b0;
                  end
`endif
               end
               D_EXT: begin
                  if (byte_q == 8'hF0) begin
                     dec_q <= D_EXT_BRK;
                  end else begin
                     if (arrow_hit[2]) begin
                        dir_q        <= arrow_hit[1:0];
                        dir_strobe_q <= 1'b1;
                        key_held_q   <= 1'b1;
                        held_code_q  <= byte_q;
                        held_ext_q   <= 1'b1;
                     end
                     dec_q <= D_IDLE;
                  end
               end
               D_EXT_BRK: begin
                  if (held_ext_q && byte_q == held_code_q) key_held_q <= 1'b0;
                  dec_q <= D_IDLE;
               end
               default: begin
`ifdef PS2_DIR_WASD_EN
                  if (!held_ext_q && byte_q == held_code_q) key_held_q <= 1'b0;
`endif
                  dec_q <= D_IDLE;
               end
            endcase
         end
      end
   end

   assign dir        = dir_q;
   assign dir_strobe = dir_strobe_q;
   assign key_held   = key_held_q;
   assign frame_err  = frame_err_q;

endmodule
